// File: rtl/div_seq_core_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_seq_core_pkg;

  // Default operand / quotient width.
  localparam int DIV_WIDTH = 4;

  // Iteration counter width for the default width.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Control FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : div_seq_core_pkg

// File: rtl/div_seq_core_if.sv
// Request/result bundle between the calculator and the divider core.
import div_seq_core_pkg::*;

interface div_seq_core_if #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Calculator side: issues operands, observes status and results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface : div_seq_core_if

// File: rtl/div_seq_core_step.sv
// One restoring-division iteration: shift, trial subtract, restore-select.
import div_seq_core_pkg::*;

module div_seq_core_step #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r_i,      // partial remainder
  input  logic             q_msb_i,  // next dividend bit shifted in
  input  logic [WIDTH-1:0] d_i,      // divisor
  output logic [WIDTH:0]   r_o,      // next partial remainder
  output logic             sel_o     // quotient bit / restore-select
);
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;
  // Top remainder bit is always 0 because R < D; it is shifted out unused.
  logic           unused_r_msb;

  assign unused_r_msb = r_i[WIDTH];
  assign r_sh  = {r_i[WIDTH-1:0], q_msb_i};
  assign diff  = r_sh - {1'b0, d_i};
  // Non-negative difference means the divisor fits: keep diff, quotient bit 1.
  assign sel_o = ~diff[WIDTH];
  assign r_o   = sel_o ? diff : r_sh;
endmodule : div_seq_core_step

// File: rtl/div_seq_core.sv
// Sequential restoring divider: one quotient bit per clock, registered results.
import div_seq_core_pkg::*;

module div_seq_core #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  div_seq_core_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_r;
  logic             step_sel;

  div_seq_core_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[WIDTH-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .sel_o   (step_sel)
  );

  // Next-state: accept in IDLE, iterate in RUN, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          d_d   = bus.divisor;
          q_d   = bus.dividend;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            // Results are known immediately; skip the iteration phase.
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        r_d   = step_r;
        q_d   = {q_q[WIDTH-2:0], step_sel};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          quot_d  = {q_q[WIDTH-2:0], step_sel};
          rem_d   = step_r[WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule : div_seq_core

// File: tb/tb_div_seq_core.sv
// Self-checking bench for div_seq_core: vector table, corner sequences, random sweep.
module tb_div_seq_core;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  div_seq_core_if #(.WIDTH(W)) bus ();

  div_seq_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int eq;
    int er;
    int ez;
    int ebusy;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero yields all-ones / dividend.
  task automatic model(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endtask

  // One operation from a negedge: start pulse, scramble operands after accept,
  // count busy cycles until done, and report whether done lasted one cycle.
  task automatic do_op(input int a, input int b, output int q, output int r,
                       output int z, output int bc, output int tout, output int done2);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    bc   = 0;
    tout = 1;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        tout = 0;
        break;
      end
      if (bus.busy) bc++;
      @(negedge clk);
    end
    q = int'(bus.quotient);
    r = int'(bus.remainder);
    z = int'(bus.div_by_zero);
    @(negedge clk);
    done2 = int'(bus.done);
  endtask

  initial begin
    vec_t vecs[6];
    int q, r, z, bc, tout, d2;
    int eq, er, ez;
    int ndone, t_last, nseen;

    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{13, 4, 3, 1, 0, 4};
    vecs[1] = '{15, 1, 15, 0, 0, 4};
    vecs[2] = '{3, 7, 0, 3, 0, 4};
    vecs[3] = '{15, 15, 1, 0, 0, 4};
    vecs[4] = '{9, 0, 15, 9, 1, 0};
    vecs[5] = '{8, 2, 4, 0, 0, 4};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quot", int'(bus.quotient), 0);
    chk("rst_rem", int'(bus.remainder), 0);
    chk("rst_dbz", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, q, r, z, bc, tout, d2);
      chk("vec_timeout", tout, 0);
      chk("vec_quot", q, vecs[i].eq);
      chk("vec_rem", r, vecs[i].er);
      chk("vec_dbz", z, vecs[i].ez);
      chk("vec_busy_cycles", bc, vecs[i].ebusy);
      chk("vec_done_width", d2, 0);
    end

    // Start pulsed during RUN is ignored; operand changes have no effect.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd4;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd6; bus.divisor = 4'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = 4'd1; bus.divisor = 4'd1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        ndone++;
        chk("busy_start_quot", int'(bus.quotient), 3);
        chk("busy_start_rem", int'(bus.remainder), 1);
      end
      @(negedge clk);
    end
    chk("busy_start_ndone", ndone, 1);

    // Asynchronous reset two cycles into RUN.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_quot", int'(bus.quotient), 0);
    chk("mid_rst_rem", int'(bus.remainder), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("aborted_no_done", ndone, 0);
    do_op(10, 3, q, r, z, bc, tout, d2);
    chk("post_rst_timeout", tout, 0);
    chk("post_rst_quot", q, 3);
    chk("post_rst_rem", r, 1);

    // Start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd5;
    nseen  = 0;
    t_last = -1;
    for (int i = 0; i < 40 && nseen < 3; i++) begin
      @(negedge clk);
      if (bus.done) begin
        chk("b2b_quot", int'(bus.quotient), 2);
        chk("b2b_rem", int'(bus.remainder), 4);
        if (t_last >= 0) chk("b2b_period", i - t_last, W + 2);
        t_last = i;
        nseen++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", nseen, 3);
    repeat (2) @(negedge clk);

    // Random sweep against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = int'($urandom_range(0, 15));
      b = (i < 4) ? 0 : int'($urandom_range(0, 15));
      model(a, b, eq, er, ez);
      do_op(a, b, q, r, z, bc, tout, d2);
      chk("rnd_timeout", tout, 0);
      chk("rnd_quot", q, eq);
      chk("rnd_rem", r, er);
      chk("rnd_dbz", z, ez);
      chk("rnd_busy_cycles", bc, (b == 0) ? 0 : W);
      if (z == 0) chk("rnd_rem_lt_div", int'(r < b), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule : tb_div_seq_core
